// File: rtl/fir_csd_sequencer.sv
// Delay line plus evaluate/capture sequencer for a decimating FIR datapath.
// Define FIR_SEQ_WARMUP_EN to hold off results until the delay line is fully populated.
module fir_csd_tap #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] tap_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)     tap_q <= '0;
    else if (i_en) tap_q <= i_d;
  end

  assign o_q = tap_q;
endmodule

module fir_csd_sequencer #(
  parameter int I_WIDTH    = 16,
  parameter int ORDER      = 17,
  parameter int O_WIDTH    = 16,
  parameter int DECIMATION = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [I_WIDTH-1:0]         i_data,
  output logic [I_WIDTH*ORDER-1:0]   o_fir_data,
  output logic                       o_fir_en,
  input  logic [O_WIDTH-1:0]         i_fir_data,
  output logic [O_WIDTH-1:0]         o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_overrun
);
  localparam int STAGES = 2;
  localparam int DCW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [DCW-1:0] DEC_LAST = DCW'(DECIMATION - 1);

  // Delay line: every tap shifts on each accepted sample.
  logic [ORDER-1:0][I_WIDTH-1:0] line_q, line_d;

  assign line_d[0] = i_data;
  for (genvar k = 1; k < ORDER; k++) begin : g_link
    assign line_d[k] = line_q[k-1];
  end

  for (genvar k = 0; k < ORDER; k++) begin : g_tap
    fir_csd_tap #(.W(I_WIDTH)) u_tap (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_valid),
      .i_d   (line_d[k]),
      .o_q   (line_q[k])
    );
  end

  assign o_fir_data = line_q;

  logic           in_fill, fill_trig, run_trig, trig;
  logic [DCW-1:0] dec_q, dec_d;

`ifdef FIR_SEQ_WARMUP_EN
  localparam int FCW = $clog2(ORDER + 1);
  localparam logic [FCW-1:0] FILL_LAST = FCW'(ORDER - 1);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [FCW-1:0] fill_q, fill_d;

  // The ORDER-th sample completes the line and is itself the first trigger.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    fill_trig = 1'b0;
    if (i_valid && state_q == S_FILL) begin
      if (fill_q == FILL_LAST) begin
        fill_trig = 1'b1;
        state_d   = S_RUN;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FILL;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  assign in_fill = (state_q == S_FILL);
`else
  assign in_fill   = 1'b0;
  assign fill_trig = 1'b0;
`endif

  always_comb begin
    dec_d    = dec_q;
    run_trig = 1'b0;
    if (i_valid && !in_fill) begin
      if (dec_q == DEC_LAST) begin
        dec_d    = '0;
        run_trig = 1'b1;
      end else begin
        dec_d = dec_q + 1'b1;
      end
    end
    if (fill_trig) dec_d = '0;
  end

  assign trig = fill_trig | run_trig;

  // Token per evaluation: stage 1 is the datapath strobe, stage 2 the capture slot.
  logic [STAGES:1] vld_pipe_q;
  logic            cap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dec_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      dec_q      <= dec_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], trig};
    end
  end

  assign o_fir_en = vld_pipe_q[1];
  assign cap      = vld_pipe_q[STAGES];

  logic [O_WIDTH-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (cap) begin
      data_d  = i_fir_data;
      valid_d = 1'b1;
      if (valid_q && !i_ready) ovr_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_fir_csd_sequencer.sv
// Bench for fir_csd_sequencer: directed table scenarios, then random traffic vs. a sample-history model.
module tb_fir_csd_sequencer;
  localparam int IW = 16, ORD = 17, OW = 16, DEC = 4, NCYC = 26, NRAND = 3000;
  localparam int LW = IW * ORD;

  logic          clk = 1'b0;
  logic          rst, iv, rdy;
  logic [IW-1:0] id;
  logic [LW-1:0] line;
  logic          en, ovl, ovr;
  logic [OW-1:0] fir_res_q, odat;

  int n_vec = 0, n_miss = 0, cyc = 0;

  always #5 clk = ~clk;

  fir_csd_sequencer #(.I_WIDTH(IW), .ORDER(ORD), .O_WIDTH(OW), .DECIMATION(DEC)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(iv), .i_data(id), .o_fir_data(line),
    .o_fir_en(en), .i_fir_data(fir_res_q), .o_data(odat), .o_valid(ovl),
    .i_ready(rdy), .o_overrun(ovr)
  );

  // Datapath stub: tap0 + tap(ORD-1), registered on the evaluate strobe.
  always @(posedge clk)
    if (en) fir_res_q <= OW'(line[0 +: IW] + line[(ORD-1)*IW +: IW]);

  // ---------------- reference model ----------------
  logic [IW-1:0] hist [ORD];
  int            m_n;
  int            en_q[$], cap_c[$];
  logic [OW-1:0] cap_v[$];
  logic          m_en, m_vl, m_ovr;
  logic [OW-1:0] m_dat;
  logic [LW-1:0] m_line;

  function automatic bit is_trig(input int n);
`ifdef FIR_SEQ_WARMUP_EN
    return (n == ORD) || (n > ORD && ((n - ORD) % DEC) == 0);
`else
    return (n % DEC) == 0;
`endif
  endfunction

  task automatic model_step();
    logic [OW-1:0] v;
    if (rst) begin
      foreach (hist[k]) hist[k] = '0;
      m_n = 0; en_q.delete(); cap_c.delete(); cap_v.delete();
      m_vl = 0; m_dat = '0; m_ovr = 0;
    end else begin
      if (cap_c.size() > 0 && cap_c[0] == cyc) begin
        if (m_vl && !rdy) m_ovr = 1;
        m_dat = cap_v[0]; m_vl = 1;
        void'(cap_c.pop_front()); void'(cap_v.pop_front());
      end else if (m_vl && rdy) m_vl = 0;
      if (iv) begin
        for (int k = ORD - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = id; m_n++;
        if (is_trig(m_n)) begin
          v = OW'(hist[0] + hist[ORD-1]);
          en_q.push_back(cyc + 1); cap_c.push_back(cyc + 2); cap_v.push_back(v);
        end
      end
      while (en_q.size() > 0 && en_q[0] < cyc + 1) void'(en_q.pop_front());
    end
    m_en = (en_q.size() > 0 && en_q[0] == cyc + 1);
    for (int k = 0; k < ORD; k++) m_line[k*IW +: IW] = hist[k];
  endtask

  task automatic tick(input logic r, input logic v, input logic [IW-1:0] d, input logic rd);
    rst = r; iv = v; id = d; rdy = rd;
    model_step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic r, v; logic [IW-1:0] d; logic rd;
    logic en, vl; logic [OW-1:0] dat; logic ovr;
    logic chk_line; logic [LW-1:0] ln;
  } vec_t;
  vec_t tv [NCYC];

`ifdef FIR_SEQ_WARMUP_EN
  localparam int NSCN = 4;
`else
  localparam int NSCN = 3;
`endif

  task automatic build(input int s);
    for (int c = 0; c < NCYC; c++) begin
      tv[c].r = 0; tv[c].v = 0; tv[c].d = '0; tv[c].rd = 0;
      tv[c].en = 0; tv[c].vl = 0; tv[c].dat = '0; tv[c].ovr = 0;
      tv[c].chk_line = 0; tv[c].ln = '0;
    end
`ifdef FIR_SEQ_WARMUP_EN
    if (s < 3) begin
      for (int c = 0; c < 21; c++) begin tv[c].v = 1; tv[c].d = IW'(c + 1); end
      tv[17].en = 1; tv[21].en = 1;
      tv[17].chk_line = 1;
      for (int k = 0; k < ORD; k++) tv[17].ln[k*IW +: IW] = IW'(17 - k);
    end
    if (s == 0) begin
      for (int c = 0; c < NCYC; c++) tv[c].rd = 1;
      tv[19].vl = 1; tv[19].dat = 18;
      tv[23].vl = 1; tv[23].dat = 26;
    end else if (s == 1 || s == 2) begin
      if (s == 2) tv[22].rd = 1;
      for (int c = 19; c < NCYC; c++) begin
        tv[c].vl = 1; tv[c].dat = (c < 23) ? OW'(18) : OW'(26);
        tv[c].ovr = (s == 1 && c >= 23);
      end
    end else begin
      for (int c = 0; c < 18; c++) begin tv[c].v = 1; tv[c].d = IW'(c + 1); end
      tv[18].r = 1; tv[18].v = 1; tv[18].d = 19;
      for (int c = 19; c < NCYC - 1; c++) begin tv[c].v = 1; tv[c].d = IW'(100 + c); end
      tv[17].en = 1;
      tv[19].chk_line = 1;
    end
`else
    if (s < 2) begin
      for (int c = 0; c < 8; c++) begin tv[c].v = 1; tv[c].d = IW'(c + 1); end
      tv[4].en = 1; tv[8].en = 1;
      tv[4].chk_line = 1;
      for (int k = 0; k < 4; k++) tv[4].ln[k*IW +: IW] = IW'(4 - k);
    end
    if (s == 0) begin
      for (int c = 7; c < NCYC; c++) tv[c].rd = 1;
      tv[6].vl = 1; tv[6].dat = 4;
      tv[7].vl = 1; tv[7].dat = 4;
      tv[10].vl = 1; tv[10].dat = 8;
    end else if (s == 1) begin
      for (int c = 6; c < NCYC; c++) begin
        tv[c].vl = 1; tv[c].dat = (c < 10) ? OW'(4) : OW'(8); tv[c].ovr = (c >= 10);
      end
    end else begin
      for (int c = 0; c < 4; c++) begin tv[c].v = 1; tv[c].d = IW'(c + 1); end
      tv[4].r = 1; tv[4].v = 1; tv[4].d = 5;
      tv[4].en = 1;
      tv[5].chk_line = 1;
    end
`endif
  endtask

  task automatic run_scn(input int s);
    build(s);
    tick(1, 0, '0, 0);
    cyc = 0;
    for (int c = 0; c < NCYC; c++) begin
      chk($sformatf("s%0d fir_en", s), LW'(en), LW'(tv[c].en));
      chk($sformatf("s%0d valid", s), LW'(ovl), LW'(tv[c].vl));
      chk($sformatf("s%0d overrun", s), LW'(ovr), LW'(tv[c].ovr));
      if (tv[c].vl) chk($sformatf("s%0d data", s), LW'(odat), LW'(tv[c].dat));
      if (tv[c].chk_line) chk($sformatf("s%0d line", s), line, tv[c].ln);
      tick(tv[c].r, tv[c].v, tv[c].d, tv[c].rd);
    end
  endtask

  initial begin
    rst = 1; iv = 0; id = '0; rdy = 0;
    tick(1, 0, '0, 0);
    chk("reset valid", LW'(ovl), '0);
    chk("reset data", LW'(odat), '0);
    chk("reset overrun", LW'(ovr), '0);
    chk("reset fir_en", LW'(en), '0);
    chk("reset line", line, '0);

    for (int s = 0; s < NSCN; s++) run_scn(s);

    tick(1, 0, '0, 0);
    for (int i = 0; i < NRAND; i++) begin
      chk("rnd fir_en", LW'(en), LW'(m_en));
      chk("rnd valid", LW'(ovl), LW'(m_vl));
      chk("rnd data", LW'(odat), LW'(m_dat));
      chk("rnd overrun", LW'(ovr), LW'(m_ovr));
      chk("rnd line", line, m_line);
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 6,
           IW'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fir_csd_sequencer.md
FIR_CSD_SEQUENCER -- requirements
Module: fir_csd_sequencer

Interface
REQ-001 SHALL have parameter I_WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter ORDER, default 17, number of delay-line taps.
REQ-003 SHALL have parameter O_WIDTH, default 16, width of the filter result.
REQ-004 SHALL have parameter DECIMATION, default 4, accepted samples per evaluation (legal range 1..255).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports named i_clk and i_rst.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port i_valid, input, 1 bit: i_data is accepted on any cycle where i_valid is high.
REQ-009 SHALL have port i_data, input, I_WIDTH bits: input sample.
REQ-010 SHALL have port o_fir_data, output, I_WIDTH*ORDER bits: packed delay line to the FIR datapath; tap k is at bits [k*I_WIDTH +: I_WIDTH], and tap 0 is the newest sample.
REQ-011 SHALL have port o_fir_en, output, 1 bit: the evaluate strobe to the datapath.
REQ-012 SHALL have port i_fir_data, input, O_WIDTH bits: the registered result from the datapath, which has one cycle of latency.
REQ-013 SHALL have port o_data, output, O_WIDTH bits: the held result.
REQ-014 SHALL have port o_valid, output, 1 bit: o_data holds an unconsumed result.
REQ-015 SHALL have port i_ready, input, 1 bit: the consumer takes o_data when o_valid and i_ready are both high.
REQ-016 SHALL have port o_overrun, output, 1 bit: sticky flag meaning an unconsumed result was overwritten.

Function
REQ-017 SHALL, on each accepted sample, shift the delay line: tap 0 takes i_data, and tap k takes the old tap k-1 for k = 1..ORDER-1.
REQ-018 SHALL drive o_fir_data directly from the delay-line registers.
REQ-019 SHALL keep a decimation counter, 0..DECIMATION-1, which increments per accepted sample in RUN and wraps to 0.
REQ-020 SHALL mark the sample that wraps the counter as the trigger sample.
REQ-021 SHALL, for a trigger sample accepted in cycle T, assert o_fir_en for exactly cycle T+1, when the datapath sees the updated line.
REQ-022 SHALL, for the same trigger, capture i_fir_data into o_data at the end of cycle T+2, so o_valid goes high from cycle T+3 (3-cycle latency).
REQ-023 SHALL track in-flight evaluations with a 2-stage token pipeline, so back-to-back triggers (DECIMATION=1, i_valid continuously high) each produce a result.
REQ-024 SHALL NOT stall or disturb an in-flight result when samples arrive in cycle T+1 or T+2.
REQ-025 SHALL clear o_valid when o_valid=1, i_ready=1, and no capture occurs that cycle.
REQ-026 SHALL, when a capture coincides with i_ready=1, load the new result, keep o_valid=1, and leave o_overrun unchanged.
REQ-027 SHALL, when a capture occurs while o_valid=1 and i_ready=0, overwrite o_data and set o_overrun=1.
REQ-028 SHALL clear o_overrun only by reset.
REQ-029 SHALL have state machine states FILL and RUN.
REQ-030 SHALL, in FILL, count accepted samples in the fill counter.
REQ-031 SHALL, on the ORDER-th accepted sample, treat that sample as a trigger, move to RUN, and reset the decimation counter to 0.
REQ-032 SHALL, in RUN, generate triggers per REQ-019 and REQ-020.
REQ-033 SHALL ignore i_data entirely when i_valid=0; no shift and no count.

Reset
REQ-034 SHALL, on reset, clear all delay-line taps to 0.
REQ-035 SHALL, on reset, clear the decimation counter, fill counter and token pipeline to 0.
REQ-036 SHALL, on reset, set o_fir_en=0, o_valid=0, o_data=0 and o_overrun=0.
REQ-037 SHALL enter FILL on reset if FIR_SEQ_WARMUP_EN is defined, and RUN otherwise.
REQ-038 SHALL discard in-flight evaluations when reset is asserted mid-operation; no o_valid results from them after reset.
REQ-039 SHALL give reset priority over a simultaneous i_valid.

Configuration
REQ-040 SHALL use macro FIR_SEQ_WARMUP_EN.
REQ-041 SHALL, when FIR_SEQ_WARMUP_EN is defined, implement FILL per REQ-029 to REQ-031, so no result is produced from a partly zero delay line.
REQ-042 SHALL, when FIR_SEQ_WARMUP_EN is undefined, omit FILL and the fill counter, start in RUN, and trigger every DECIMATION-th accepted sample from reset.

Verification (ORDER=17, DECIMATION=4, I_WIDTH=16; datapath stub returns tap0+tap16, truncated to 16 bits, registered)
REQ-043 SHALL verify warm-up (macro defined): reset, then samples 1..17 with i_valid=1 every cycle from cycle 0 -> o_fir_en only in cycle 17, o_valid rises in cycle 19, o_data=18 (17+1).
REQ-044 SHALL verify steady state: continue the REQ-043 bench with samples 18..21, i_ready=1 -> next o_valid in cycle 23, o_data=26 (21+5), and no other o_fir_en pulses.
REQ-045 SHALL verify overrun: the REQ-044 bench with i_ready=0 throughout -> o_data=26 after the second result, o_overrun=1, o_valid held high.
REQ-046 SHALL verify coincident consume: i_ready pulses 1 exactly in the capture cycle of the second result -> o_valid stays 1, o_data=26, o_overrun=0.
REQ-047 SHALL verify reset mid-pipeline: i_rst=1 in cycle 18 of the REQ-043 bench -> o_valid never rises, o_fir_data all zero, state FILL.
REQ-048 SHALL verify no-warm-up (macro undefined): samples 1..4 after reset -> o_fir_en in cycle 4, o_data=4 (4+0), taps 4..16 zero.
